// File: rtl/dac_pkg.sv
// Shared definitions for the sine-table DAC sequencer: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package dac_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STEP   = 2'd1;
    localparam logic [1:0] REG_BURST  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_CONT     = 2;
    localparam int CTRL_USE_TRIG = 3;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_ARMED = 1;
    localparam int STATUS_DONE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/dac_wave_ctrl_if.sv
// Avalon-MM register port of the DAC sequencer; the Nios side is the master.
interface dac_wave_ctrl_if;

    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );

endinterface

// File: rtl/dac_phase_acc.sv
// Modulo-TABLE_LEN phase accumulator; wrap flags the cycle whose update
// crosses the end of the table.
module dac_phase_acc #(
    parameter int TABLE_LEN = 39,
    parameter int ADDR_W    = 7
) (
    input  logic              ref_clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    localparam logic [ADDR_W:0] LEN = (ADDR_W + 1)'(TABLE_LEN);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   sum;

    // wrap ignores clear so the controller can clear in response to it
    always_comb begin
        sum    = {1'b0, addr_q} + {1'b0, step};
        wrap   = enable && (sum >= LEN);
        addr_d = addr_q;
        if (clear) begin
            addr_d = '0;
        end else if (enable) begin
            if (wrap) begin
                addr_d = ADDR_W'(sum - LEN);
            end else begin
                addr_d = sum[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/dac_wave_ctrl.sv
// DAC waveform sequencer: Avalon-MM register file, IDLE/ARMED/RUN control
// and burst counting around the modulo phase accumulator.
module dac_wave_ctrl
    import dac_pkg::*;
#(
    parameter int TABLE_LEN = 39,
    parameter int ADDR_W    = 7,
    parameter int BURST_W   = 16
) (
    input  logic              ref_clk,
    input  logic              reset_n,
    dac_wave_ctrl_if.slave    avs,
    input  logic              trigger,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              dac_en,
    output logic              done_irq
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  step_q, step_d, step_sh_q, step_sh_d;
    logic [BURST_W-1:0] burst_q, burst_d, cnt_q, cnt_d;
    logic               cont_q, cont_d, use_trig_q, use_trig_d;
    logic               done_q, done_d, trig_q, trig_d;
    logic [31:0]        rdata_q, rdata_d, ctrl_rd, status_rd;
    logic               start, stop, trig_rise, enter_run, done_set;
    logic               acc_clear, acc_en, acc_wrap;

    dac_phase_acc #(
        .TABLE_LEN (TABLE_LEN),
        .ADDR_W    (ADDR_W)
    ) u_phase_acc (
        .ref_clk (ref_clk),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .enable  (acc_en),
        .step    (step_sh_q),
        .addr    (rom_addr),
        .wrap    (acc_wrap)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        step_sh_d  = step_sh_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        cont_d     = cont_q;
        use_trig_d = use_trig_q;
        done_d     = done_q;
        trig_d     = trigger;
        rdata_d    = rdata_q;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        enter_run  = 1'b0;
        done_set   = 1'b0;
        start      = avs.avs_write && (avs.avs_address == REG_CTRL) && avs.avs_writedata[CTRL_START];
        stop       = avs.avs_write && (avs.avs_address == REG_CTRL) && avs.avs_writedata[CTRL_STOP];
        trig_rise  = trigger && !trig_q;

        if (avs.avs_write) begin
            unique case (avs.avs_address)
                REG_CTRL: begin
                    cont_d     = avs.avs_writedata[CTRL_CONT];
                    use_trig_d = avs.avs_writedata[CTRL_USE_TRIG];
                end
                REG_STEP: begin
                    if (avs.avs_writedata == 32'd0 || avs.avs_writedata >= 32'(TABLE_LEN)) begin
                        step_d = ADDR_W'(1);
                    end else begin
                        step_d = avs.avs_writedata[ADDR_W-1:0];
                    end
                end
                REG_BURST: begin
                    if (avs.avs_writedata[BURST_W-1:0] == '0) begin
                        burst_d = BURST_W'(1);
                    end else begin
                        burst_d = avs.avs_writedata[BURST_W-1:0];
                    end
                end
                REG_STATUS: begin
                    if (avs.avs_writedata[STATUS_DONE]) begin
                        done_d = 1'b0;
                    end
                end
            endcase
        end

        // start decides ARMED vs RUN from the use_trig bit written alongside it
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (avs.avs_writedata[CTRL_USE_TRIG]) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d   = ST_RUN;
                        enter_run = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (trig_rise) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    acc_clear = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    if (acc_wrap) begin
                        step_sh_d = step_q;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + BURST_W'(1);
                        end
                        if (!cont_q && cnt_d == burst_q) begin
                            state_d   = ST_IDLE;
                            acc_clear = 1'b1;
                            done_set  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_run) begin
            step_sh_d = step_q;
            cnt_d     = '0;
            acc_clear = 1'b1;
        end
        if (done_set) begin
            done_d = 1'b1;
        end

        ctrl_rd                   = '0;
        ctrl_rd[CTRL_CONT]        = cont_q;
        ctrl_rd[CTRL_USE_TRIG]    = use_trig_q;
        status_rd                 = '0;
        status_rd[STATUS_BUSY]    = (state_q == ST_RUN);
        status_rd[STATUS_ARMED]   = (state_q == ST_ARMED);
        status_rd[STATUS_DONE]    = done_q;
        status_rd[31:16]          = 16'(cnt_q);

        if (avs.avs_read) begin
            unique case (avs.avs_address)
                REG_CTRL:   rdata_d = ctrl_rd;
                REG_STEP:   rdata_d = 32'(step_q);
                REG_BURST:  rdata_d = 32'(burst_q);
                REG_STATUS: rdata_d = status_rd;
            endcase
        end
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            step_q     <= ADDR_W'(1);
            step_sh_q  <= ADDR_W'(1);
            burst_q    <= BURST_W'(1);
            cnt_q      <= '0;
            cont_q     <= 1'b0;
            use_trig_q <= 1'b0;
            done_q     <= 1'b0;
            trig_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            step_sh_q  <= step_sh_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            cont_q     <= cont_d;
            use_trig_q <= use_trig_d;
            done_q     <= done_d;
            trig_q     <= trig_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dac_en           = (state_q == ST_RUN);
    assign done_irq         = done_q;
    assign avs.avs_readdata = rdata_q;

endmodule
